// File: rtl/soc_boot_pkg.sv
// rtl/soc_boot_pkg.sv - state encoding and bus constants shared by soc_boot_loader
package soc_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_VRF,
        ST_NEXT,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [3:0]  SEL_ALL    = 4'hF;
    localparam logic [31:0] IMG_STRIDE = 32'h1 << 26;

endpackage

// File: rtl/soc_boot_loader.sv
// rtl/soc_boot_loader.sv - Wishbone boot copier (ROM image -> RAM), then CPU reset release
// Optional SOC_BOOT_LOADER_VERIFY_EN: read back each written word and abort on mismatch.
module soc_boot_loader
    import soc_boot_pkg::*;
#(
    parameter logic [31:0] SRC_BASE   = 32'h0400_0000,
    parameter logic [31:0] DST_BASE   = 32'h0000_0000,
    parameter int unsigned WORDS      = 256,
    parameter int unsigned RETRY_MAX  = 4,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        mem_clk_i,
    input  logic        mem_rst_i,
    input  logic [1:0]  boot_select,
    input  logic        start_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic [3:0]  mem_sel_o,
    output logic        mem_we_o,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    input  logic        mem_ack_i,
    input  logic        mem_err_i,
    input  logic        mem_rty_i,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int CNT_W = (WORDS > 0) ? $clog2(WORDS + 1) : 1;

    state_t             state_q, state_n;
    logic [31:0]        src_q, src_n;
    logic [31:0]        dst_q, dst_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [31:0]        data_q, data_n;
    logic [31:0]        retry_q, retry_n;
    logic               settle_q;
    logic               cyc_q, stb_q, stb_n, we_q;
    logic [31:0]        addr_q, addr_n;
    logic               done_q, error_q, cpu_rst_q;
    logic               access_n;

    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign mem_sel_o  = SEL_ALL;
    assign mem_we_o   = we_q;
    assign mem_cyc_o  = cyc_q;
    assign mem_stb_o  = stb_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

    always_comb begin
        state_n = state_q;
        src_n   = src_q;
        dst_n   = dst_q;
        cnt_n   = cnt_q;
        data_n  = data_q;
        retry_n = retry_q;
        stb_n   = stb_q;

        case (state_q)
            ST_IDLE: begin
                src_n   = SRC_BASE + 32'({boot_select, 26'b0});
                dst_n   = DST_BASE;
                cnt_n   = CNT_W'(WORDS);
                retry_n = '0;
                // settle_q holds IDLE for one cycle after reset release
                if (!settle_q && (AUTO_START || start_i))
                    state_n = (WORDS == 0) ? ST_DONE : ST_RD;
            end
            ST_RD, ST_WR, ST_VRF: begin
                if (!stb_q) begin
                    stb_n = 1'b1;
                end else if (mem_err_i) begin
                    state_n = ST_FAIL;
                end else if (mem_ack_i) begin
                    retry_n = '0;
                    if (state_q == ST_RD) begin
                        data_n  = mem_data_i;
                        state_n = ST_WR;
                    end
`ifdef SOC_BOOT_LOADER_VERIFY_EN
                    else if (state_q == ST_WR)
                        state_n = ST_VRF;
                    else
                        state_n = (mem_data_i == data_q) ? ST_NEXT : ST_FAIL;
`else
                    else
                        state_n = ST_NEXT;
`endif
                end else if (mem_rty_i) begin
                    // one strobe-low gap, then the identical access is reissued
                    if (retry_q >= RETRY_MAX) begin
                        state_n = ST_FAIL;
                    end else begin
                        retry_n = retry_q + 32'd1;
                        stb_n   = 1'b0;
                    end
                end
            end
            ST_NEXT: begin
                src_n   = src_q + 32'd4;
                dst_n   = dst_q + 32'd4;
                cnt_n   = cnt_q - CNT_W'(1);
                state_n = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_RD;
            end
            default: ;
        endcase

        access_n = state_n inside {ST_RD, ST_WR, ST_VRF};
        if (state_n != state_q)
            stb_n = access_n;
        addr_n = (state_n == ST_RD) ? src_n : (access_n ? dst_n : addr_q);
    end

    always_ff @(posedge mem_clk_i) begin
        if (mem_rst_i) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            retry_q   <= '0;
            settle_q  <= 1'b1;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_n;
            src_q     <= src_n;
            dst_q     <= dst_n;
            cnt_q     <= cnt_n;
            data_q    <= data_n;
            retry_q   <= retry_n;
            settle_q  <= 1'b0;
            cyc_q     <= access_n;
            stb_q     <= stb_n;
            we_q      <= (state_n == ST_WR);
            addr_q    <= addr_n;
            done_q    <= (state_n == ST_DONE);
            error_q   <= (state_n == ST_FAIL);
            cpu_rst_q <= (state_n != ST_DONE);
        end
    end

endmodule

// File: tb/tb_soc_boot_loader.sv
// tb/tb_soc_boot_loader.sv - randomized bench for soc_boot_loader against a ROM/RAM slave model
module tb_soc_boot_loader;

    localparam int N = 8;
`ifdef SOC_BOOT_LOADER_VERIFY_EN
    localparam int PER_WORD = 4;
`else
    localparam int PER_WORD = 3;
`endif
    localparam logic [31:0] ROM_LO = 32'h0400_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  boot_select = 2'd0;
    logic        start_i = 1'b0;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic [3:0]  mem_sel_o;
    logic        mem_we_o, mem_cyc_o, mem_stb_o, mem_ack_i, mem_err_i, mem_rty_i;
    logic        cpu_rst_o, done_o, error_o;
    logic [31:0] b_addr, b_data;
    logic [3:0]  b_sel;
    logic        b_we, b_cyc, b_stb, b_cpu_rst, b_done, b_error;

    always #5 clk = ~clk;

    soc_boot_loader #(.WORDS(N), .RETRY_MAX(4)) dut (
        .mem_clk_i(clk), .mem_rst_i(rst), .boot_select(boot_select), .start_i(start_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_sel_o(mem_sel_o), .mem_we_o(mem_we_o), .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o),
        .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_rty_i(mem_rty_i),
        .cpu_rst_o(cpu_rst_o), .done_o(done_o), .error_o(error_o)
    );

    soc_boot_loader #(.WORDS(0)) dut_w0 (
        .mem_clk_i(clk), .mem_rst_i(rst), .boot_select(boot_select), .start_i(start_i),
        .mem_addr_o(b_addr), .mem_data_o(b_data), .mem_data_i(32'h0),
        .mem_sel_o(b_sel), .mem_we_o(b_we), .mem_cyc_o(b_cyc), .mem_stb_o(b_stb),
        .mem_ack_i(1'b0), .mem_err_i(1'b0), .mem_rty_i(1'b0),
        .cpu_rst_o(b_cpu_rst), .done_o(b_done), .error_o(b_error)
    );

    // slave configuration, written only by the stimulus process
    int min_wait = 0, max_wait = 0, err_rd = -1, rty_word = -1, rty_num = 0, corrupt = -1;
    logic [31:0] rom [16];
    logic [31:0] ram [16];
    int rd_acks, rty_given, wait_left;
    logic [31:0] rd_q[$];
    bit          wr_rty[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  widx;

    assign widx = mem_addr_o[5:2];

    function automatic int pick_wait();
        return int'($urandom_range(max_wait, min_wait));
    endfunction

    always_comb begin
        mem_ack_i  = 1'b0;
        mem_err_i  = 1'b0;
        mem_rty_i  = 1'b0;
        mem_data_i = 32'h0;
        if (mem_cyc_o && mem_stb_o && wait_left == 0) begin
            if (mem_we_o) begin
                if (int'(widx) == rty_word && rty_given < rty_num) mem_rty_i = 1'b1;
                else mem_ack_i = 1'b1;
            end else if (mem_addr_o >= ROM_LO) begin
                mem_data_i = rom[widx];
                mem_ack_i  = 1'b1;
                if (rd_acks == err_rd) begin
                    mem_err_i = 1'b1;
                    mem_rty_i = 1'b1;
                end
            end else begin
                mem_data_i = ram[widx] ^ ((int'(widx) == corrupt) ? 32'h1 : 32'h0);
                mem_ack_i  = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            rd_acks   <= 0;
            rty_given <= 0;
            wait_left <= pick_wait();
            rd_q.delete();
            wr_rty.delete();
            wr_addr.delete();
            wr_data.delete();
            for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
        end else if (mem_cyc_o && mem_stb_o) begin
            if (mem_ack_i || mem_err_i || mem_rty_i) wait_left <= pick_wait();
            else wait_left <= wait_left - 1;
            if (mem_ack_i && !mem_err_i && !mem_we_o && mem_addr_o >= ROM_LO) begin
                rd_acks <= rd_acks + 1;
                rd_q.push_back(mem_addr_o);
            end
            if (mem_we_o && (mem_ack_i || mem_rty_i)) begin
                wr_rty.push_back(mem_rty_i);
                wr_addr.push_back(mem_addr_o);
                wr_data.push_back(mem_data_o);
            end
            if (mem_we_o && mem_ack_i) ram[widx] <= mem_data_o;
            if (mem_rty_i) rty_given <= rty_given + 1;
        end
    end

    int n_checks = 0, n_fail = 0;
    int rst_fall, b_done_cyc;
    bit b_stb_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input bit check_state);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if (check_state) begin
            check("rst_bus", 32'({mem_cyc_o, mem_stb_o, mem_we_o}), 32'd0);
            check("rst_addr", mem_addr_o, 32'h0);
            check("rst_data", mem_data_o, 32'h0);
            check("rst_sel", 32'(mem_sel_o), 32'hF);
            check("rst_flags", 32'({cpu_rst_o, done_o, error_o}), 32'b100);
        end
        rst = 1'b0;
    endtask

    task automatic run(input int budget, input bit bump, output int done_cyc, output int first_stb);
        int c;
        c = 0; done_cyc = -1; first_stb = -1; rst_fall = -1; b_done_cyc = -1; b_stb_seen = 1'b0;
        while (c < budget && done_cyc < 0) begin
            @(negedge clk);
            c++;
            if (bump && c == 4) boot_select = boot_select + 2'd1;
            if (mem_stb_o && first_stb < 0) first_stb = c;
            if (!cpu_rst_o && rst_fall < 0) rst_fall = c;
            if (b_stb || b_cyc || b_we) b_stb_seen = 1'b1;
            if (b_done && b_done_cyc < 0) b_done_cyc = c;
            if (done_o || error_o) done_cyc = c;
        end
        check("run_timeout", 32'(done_cyc >= 0), 32'd1);
    endtask

    function automatic int n_writes(input bit want_rty);
        int n = 0;
        for (int i = 0; i < wr_rty.size(); i++) if (wr_rty[i] == want_rty) n++;
        return n;
    endfunction

    task automatic check_copy(input string tag, input logic [31:0] src);
        int nw;
        nw = 0;
        check({tag, "_nrd"}, 32'(rd_q.size()), 32'(N));
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_ram%0d", tag, i), ram[i], rom[i]);
            if (i < rd_q.size()) check($sformatf("%s_rdaddr%0d", tag, i), rd_q[i], src + 32'(4 * i));
        end
        for (int i = 0; i < wr_rty.size(); i++) begin
            if (!wr_rty[i]) begin
                if (nw < N) begin
                    check($sformatf("%s_wraddr%0d", tag, nw), wr_addr[i], 32'(4 * nw));
                    check($sformatf("%s_wrdata%0d", tag, nw), wr_data[i], rom[nw]);
                end
                nw++;
            end else if (i + 1 < wr_rty.size()) begin
                check($sformatf("%s_reissue_addr%0d", tag, i), wr_addr[i + 1], wr_addr[i]);
                check($sformatf("%s_reissue_data%0d", tag, i), wr_data[i + 1], wr_data[i]);
            end
        end
        check({tag, "_nwr"}, 32'(nw), 32'(N));
    endtask

    initial begin
        int dc, fs, found;
        int rtab [3];
        logic [1:0]  bs;
        logic [31:0] src;
        bit bad;

        // zero-wait copy of image 1, plus the WORDS=0 instance
        for (int i = 0; i < 16; i++) rom[i] = 32'h1000_0000 + 32'(i);
        boot_select = 2'd1;
        do_reset(1'b1);
        run(300, 1'b0, dc, fs);
        check("zw_first_stb", 32'(fs), 32'd2);
        check("zw_done_cyc", 32'(dc), 32'(2 + N * PER_WORD));
        check("zw_cpu_rst_fall", 32'(rst_fall), 32'(dc));
        check("zw_flags", 32'({cpu_rst_o, done_o, error_o}), 32'b010);
        check("w0_done_cyc", 32'(b_done_cyc), 32'd2);
        check("w0_no_bus", 32'(b_stb_seen), 32'd0);
        check("w0_idle_out", {b_addr[15:0], b_data[15:0]}, 32'h0);
        check("w0_flags", 32'({b_sel, b_cpu_rst, b_error}), 32'hF << 2);
        check_copy("zw", ROM_LO + 32'h0400_0000);

        // random images, random wait states, boot_select changed mid-copy
        for (int t = 0; t < 3; t++) begin
            bs = 2'($urandom_range(3, 0));
            for (int i = 0; i < 16; i++) rom[i] = $urandom;
            boot_select = bs;
            min_wait = 0; max_wait = 3;
            do_reset(1'b0);
            run(800, 1'b1, dc, fs);
            src = ROM_LO + 32'(bs) * 32'h0400_0000;
            check($sformatf("rnd%0d_flags", t), 32'({cpu_rst_o, done_o, error_o}), 32'b010);
            check_copy($sformatf("rnd%0d", t), src);
        end

        // err (with ack and rty also high) on the third read
        boot_select = 2'd0;
        err_rd = 2;
        do_reset(1'b0);
        run(800, 1'b0, dc, fs);
        check("err_flags", 32'({cpu_rst_o, done_o, error_o}), 32'b101);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_cyc_o || mem_stb_o || done_o || !cpu_rst_o) bad = 1'b1;
        end
        check("err_bus_idle", 32'(bad), 32'd0);
        check("err_nwr", 32'(n_writes(1'b0)), 32'd2);
        err_rd = -1;

        // retries on word 3's write: within, at and beyond RETRY_MAX
        rtab = '{2, 4, 5};
        for (int t = 0; t < 3; t++) begin
            rty_word = 3; rty_num = rtab[t];
            do_reset(1'b0);
            run(800, 1'b0, dc, fs);
            check($sformatf("rty%0d_nrty", rtab[t]), 32'(n_writes(1'b1)), 32'(rtab[t]));
            if (rtab[t] <= 4) begin
                check($sformatf("rty%0d_flags", rtab[t]), 32'({cpu_rst_o, done_o, error_o}), 32'b010);
                check_copy($sformatf("rty%0d", rtab[t]), ROM_LO);
            end else begin
                check("rty5_flags", 32'({cpu_rst_o, done_o, error_o}), 32'b101);
                check("rty5_nwr", 32'(n_writes(1'b0)), 32'd3);
            end
        end
        rty_word = -1; rty_num = 0;

`ifdef SOC_BOOT_LOADER_VERIFY_EN
        corrupt = 5;
        do_reset(1'b0);
        run(800, 1'b0, dc, fs);
        check("vrf_flags", 32'({cpu_rst_o, done_o, error_o}), 32'b101);
        check("vrf_nwr", 32'(n_writes(1'b0)), 32'd6);
        for (int i = 0; i < 5; i++) check($sformatf("vrf_ram%0d", i), ram[i], rom[i]);
        corrupt = -1;
`endif

        // reset while a read is held in a 3-cycle wait state
        bs = 2'($urandom_range(3, 0));
        boot_select = bs;
        min_wait = 3; max_wait = 3;
        do_reset(1'b0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (mem_stb_o) found = 1;
        end
        check("mr_stb_seen", 32'(found), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mr_bus_drop", 32'({mem_cyc_o, mem_stb_o}), 32'd0);
        rst = 1'b0;
        run(800, 1'b0, dc, fs);
        check("mr_first_stb", 32'(fs), 32'd2);
        check("mr_flags", 32'({cpu_rst_o, done_o, error_o}), 32'b010);
        check_copy("mr", ROM_LO + 32'(bs) * 32'h0400_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
